// File: rtl/pc_pkg.sv
// Shared encodings and defaults for the fetch-stage program counter.
package pc_pkg;

  // Architectural state encoding; 2'd3 is unused and recovers to BOOT.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  // Source of the next PC value.
  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_INC    = 2'd1,
    SEL_TARGET = 2'd2,
    SEL_EXC    = 2'd3
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_next_mux.sv
// Priority selector for the next PC, next EPC and misalignment flag.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic             i_run,
  input  logic             i_halted,
  input  logic             i_exception,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_target,
  input  logic             i_stall,
  input  logic             i_halt,
  input  logic             i_resume,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_pc_plus,
  input  logic [WIDTH-1:0] i_epc,
  output logic [WIDTH-1:0] o_next_pc,
  output logic [WIDTH-1:0] o_next_epc,
  output logic             o_misalign,
  output logic             o_enter_halt,
  output logic             o_leave_halt
);

  // Zero-width alignment collapses to an all-zero mask, disabling the check.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  pc_sel_e w_sel;
  logic    w_misaligned;

  assign w_misaligned = (i_target & ALIGN_MASK) != '0;

  // Resolve per-cycle control priority into a PC source and EPC update.
  always_comb begin
    w_sel        = SEL_HOLD;
    o_next_epc   = i_epc;
    o_misalign   = 1'b0;
    o_enter_halt = 1'b0;
    o_leave_halt = 1'b0;
    if (i_run) begin
      if (i_exception) begin
        o_next_epc = i_pc;
        w_sel      = SEL_EXC;
      end else if (i_redirect && w_misaligned) begin
        o_next_epc = i_target;
        w_sel      = SEL_EXC;
        o_misalign = 1'b1;
      end else if (i_redirect) begin
        w_sel = SEL_TARGET;
      end else if (i_stall) begin
        w_sel = SEL_HOLD;
      end else if (i_halt) begin
        o_enter_halt = 1'b1;
      end else begin
        w_sel = SEL_INC;
      end
    end else if (i_halted) begin
      if (i_exception) begin
        o_next_epc   = i_pc;
        w_sel        = SEL_EXC;
        o_leave_halt = 1'b1;
      end else if (i_resume) begin
        w_sel        = SEL_INC;
        o_leave_halt = 1'b1;
      end
    end
  end

  // Map the selected source onto the next PC value.
  always_comb begin
    o_next_pc = i_pc;
    unique case (w_sel)
      SEL_HOLD:   o_next_pc = i_pc;
      SEL_INC:    o_next_pc = i_pc_plus;
      SEL_TARGET: o_next_pc = i_target;
      SEL_EXC:    o_next_pc = EXC_VECTOR;
      default:    o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: state FSM and PC/EPC/trap registers.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      ALIGN_BITS   = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] Target,
  input  logic             Exception,
  input  logic             Halt,
  input  logic             Resume,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlus,
  output logic             FetchValid,
  output logic [WIDTH-1:0] EPC,
  output logic             MisalignTrap,
  output logic [1:0]       State
);

  pc_state_e        r_state;
  pc_state_e        w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_trap;
  logic [WIDTH-1:0] w_pc_plus;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_next_epc;
  logic             w_misalign;
  logic             w_enter_halt;
  logic             w_leave_halt;

  assign w_pc_plus = r_pc + WIDTH'(INC);

  pc_next_mux #(
    .WIDTH      (WIDTH),
    .ALIGN_BITS (ALIGN_BITS),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next (
    .i_run        (r_state == ST_RUN),
    .i_halted     (r_state == ST_HALT),
    .i_exception  (Exception),
    .i_redirect   (Redirect),
    .i_target     (Target),
    .i_stall      (Stall),
    .i_halt       (Halt),
    .i_resume     (Resume),
    .i_pc         (r_pc),
    .i_pc_plus    (w_pc_plus),
    .i_epc        (r_epc),
    .o_next_pc    (w_next_pc),
    .o_next_epc   (w_next_epc),
    .o_misalign   (w_misalign),
    .o_enter_halt (w_enter_halt),
    .o_leave_halt (w_leave_halt)
  );

  // State register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_BOOT;
    else       r_state <= w_state_next;
  end

  // Next-state logic; any unused encoding falls back to BOOT.
  always_comb begin
    w_state_next = ST_BOOT;
    case (r_state)
      ST_BOOT: w_state_next = ST_RUN;
      ST_RUN:  w_state_next = w_enter_halt ? ST_HALT : ST_RUN;
      ST_HALT: w_state_next = w_leave_halt ? ST_RUN : ST_HALT;
      default: w_state_next = ST_BOOT;
    endcase
  end

  // PC, EPC and one-cycle misalignment pulse registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc   <= RESET_VECTOR;
      r_epc  <= '0;
      r_trap <= 1'b0;
    end else begin
      r_pc   <= w_next_pc;
      r_epc  <= w_next_epc;
      r_trap <= w_misalign;
    end
  end

  assign PCResult     = r_pc;
  assign PCPlus       = w_pc_plus;
  assign EPC          = r_epc;
  assign MisalignTrap = r_trap;
  assign FetchValid   = (r_state == ST_RUN);
  assign State        = r_state;

endmodule
